decoder_scan_nto2n: RTL
=======================

# decoder_scan_nto2n

Parametrised N-to-2^N one-hot decoder with registered outputs, a valid/ready load port and a self-timed scan mode that walks every output code in order with a programmable dwell. It is the next-generation successor to the fixed 3-to-8 combinational decoder and sits between control logic and per-line enables such as row selects, chip selects and LED/mux strobes. Scan mode replaces benches and firmware stepping codes by hand.

## Interface
- N, default 3: select width; output width is 2^N; legal 1..6.
- DWELL, default 4: cycles each code is held in scan mode; legal ≥ 1.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; low forces outputs to zero and aborts any scan.
- in_valid  in  1  direct-load request.
- in_sel  in  N  code to decode.
- in_ready  out  1  combinational; high only when state = IDLE, en = 1 and start = 0.
- start  in  1  one-cycle scan request; sampled only in IDLE.
- d  out  2^N  registered one-hot output, or all-zero.
- d_valid  out  1  registered; high while d holds a decoded code.
- cur_sel  out  N  registered binary index of the active bit of d.
- scan_done  out  1  registered one-cycle pulse on scan completion.

## Operation
- Reset values: state = IDLE, d = 0, d_valid = 0, cur_sel = 0, scan_done = 0, dwell counter = 0.
- States: IDLE, SCAN, DONE.
- IDLE, direct load: on in_valid & in_ready, set d = 1 << in_sel, cur_sel = in_sel, d_valid = 1. Value holds until the next accept, en low or a scan start.
- IDLE, scan start: start & en enters SCAN with cur_sel = 0, d = 1, d_valid = 1, dwell counter = 0.
- start and in_valid together in IDLE: start wins; in_ready is low, so the load is not accepted.
- SCAN: the dwell counter increments each cycle.
  - When it reaches DWELL-1 and cur_sel < 2^N-1: cur_sel++, d shifts left by 1, counter clears.
  - When it reaches DWELL-1 and cur_sel = 2^N-1: go to DONE.
- SCAN ignores in_valid and start; in_ready = 0.
- DONE, lasting exactly one cycle: scan_done = 1, d = 0, d_valid = 0, cur_sel = 0. Then return to IDLE.
- en low in any state: next edge gives state = IDLE, d = 0, d_valid = 0, counter = 0, no scan_done. The scan is discarded and does not resume when en rises.
- rst asserted mid-scan: immediate asynchronous return to reset values; no scan_done.
- Width rule: d is always exactly one-hot or zero. cur_sel wraps never, because scan terminates at 2^N-1. The counter width is clog2(DWELL), minimum 1 bit.

## Timing
- Direct load latency: accept on edge k; d and d_valid are valid after edge k, i.e. 1 cycle.
- Back-to-back loads are allowed every cycle while in IDLE.
- Scan: start sampled at edge t.
  - Code j is on d during cycles t+1+j·DWELL through t+(j+1)·DWELL.
  - scan_done is high for the single cycle after edge t+2^N·DWELL.
  - IDLE with in_ready high resumes one cycle later.
- Total scan occupancy is 2^N·DWELL + 1 cycles.
- en falling: outputs clear at the next edge. rst clears asynchronously, with no clock required.

## Structure
- Package decoder_pkg:
  - state enum {IDLE, SCAN, DONE};
  - function onehot(sel) returning 2^N-bit 1 << sel;
  - localparam helpers W = 1 << N and CW = clog2(DWELL) (minimum 1).
- Sub-module decoder_nto2n: parametrised combinational binary-to-one-hot. It is instantiated once on the direct-load path. The scan path uses a shift.
- Top level holds the FSM, dwell counter and output registers.

## Test plan
- Reset: rst = 1 mid-scan at any cycle -> d = 00000000, d_valid = 0, scan_done = 0, cur_sel = 0 immediately, without a clock edge.
- Direct sweep, N = 3: load in_sel 0..7, one per cycle -> d = 00000001 … 10000000, each one cycle after accept; d_valid = 1 throughout.
- Scan, N = 3, DWELL = 4: start at cycle 10.
  - d = 00000001 for cycles 11–14, 00000010 for cycles 15–18, …, 10000000 for cycles 39–42.
  - scan_done pulse at cycle 43; in_ready = 1 at cycle 44.
- Collision: start = 1 and in_valid = 1 with in_sel = 5 in the same IDLE cycle -> in_ready = 0, scan begins with d = 00000001, and code 5 is never directly loaded.
- Abort: en dropped during code 3 of a scan -> d = 0 next cycle, no scan_done. Re-raising en leaves the block in IDLE with in_ready = 1.
- Parameter corners: N = 1, DWELL = 1 -> scan gives d = 01 then 10 on consecutive cycles, then scan_done. N = 6 -> direct in_sel = 63 gives bit 63 only.

Source files
------------

// File: rtl/decoder_scan_nto2n_pkg.sv
// decoder_pkg: shared types and helpers for the scanning N-to-2^N decoder.
//   state_t    : control FSM states (IDLE, SCAN, DONE)
//   dec_width  : output width for a select width n, i.e. 1 << n
//   cnt_width  : dwell counter width, clog2(dwell) but never below 1 bit
//   onehot     : 1 << sel at the widest legal width (N = 6 -> 64 bits);
//                callers truncate the result to their own 2^N width.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_N = 6;

  function automatic int dec_width(input int n);
    return 1 << n;
  endfunction

  function automatic int cnt_width(input int dwell);
    return (dwell <= 2) ? 1 : $clog2(dwell);
  endfunction

  function automatic logic [63:0] onehot(input logic [5:0] sel);
    return 64'd1 << sel;
  endfunction

endpackage

// File: rtl/decoder_scan_nto2n_if.sv
// decoder_scan_nto2n_if: load/scan control and decoded outputs of the decoder.
//   en        : block enable (low clears outputs and aborts a scan)
//   in_valid  : direct-load request, in_sel carries the code
//   in_ready  : load can be accepted this cycle
//   start     : one-cycle scan request
//   d         : one-hot or all-zero decoded output
//   d_valid   : d holds a decoded code
//   cur_sel   : binary index of the active bit of d
//   scan_done : one-cycle pulse when a scan completes
// Handshake: a load transfers on a rising edge where in_valid and in_ready
// are both high; in_ready never depends on in_valid, and the requester may
// change in_sel freely while in_valid is low.
// master = the controlling side, slave = the decoder.
interface decoder_scan_nto2n_if #(
  parameter int N = 3
);
  import decoder_pkg::*;

  localparam int W = dec_width(N);

  logic         en;
  logic         in_valid;
  logic [N-1:0] in_sel;
  logic         in_ready;
  logic         start;
  logic [W-1:0] d;
  logic         d_valid;
  logic [N-1:0] cur_sel;
  logic         scan_done;

  modport master (
    output en, in_valid, in_sel, start,
    input  in_ready, d, d_valid, cur_sel, scan_done
  );

  modport slave (
    input  en, in_valid, in_sel, start,
    output in_ready, d, d_valid, cur_sel, scan_done
  );

endinterface

// File: rtl/decoder_scan_nto2n_dec.sv
// decoder_nto2n: combinational binary-to-one-hot decoder.
//   sel : N-bit binary code
//   y   : 2^N-bit one-hot, bit sel set
module decoder_nto2n
  import decoder_pkg::*;
#(
  parameter int N = 3,
  localparam int W = 1 << N
) (
  input  logic [N-1:0] sel,
  output logic [W-1:0] y
);

  // onehot() works at the widest legal width; keep only our 2^N bits.
  assign y = W'(onehot(6'(sel)));

endmodule

// File: rtl/decoder_scan_nto2n.sv
// decoder_scan_nto2n: N-to-2^N one-hot decoder with registered outputs,
// a valid/ready direct-load port and a self-timed scan that walks every
// code 0..2^N-1, holding each for DWELL cycles, then pulses scan_done.
//   N (1..6)     : select width, output width 2^N
//   DWELL (>= 1) : cycles each code is held during a scan
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   bus       : load/scan control and decoded outputs (slave side)
//   state_dbg : current FSM state, for observation only
module decoder_scan_nto2n
  import decoder_pkg::*;
#(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  decoder_scan_nto2n_if.slave   bus,
  output state_t                state_dbg
);

  localparam int W  = dec_width(N);
  localparam int CW = cnt_width(DWELL);

  localparam logic [N-1:0]  LAST_SEL = N'(W - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [W-1:0]    d_q, d_n;
  logic            d_valid_q, d_valid_n;
  logic [N-1:0]    cur_q, cur_n;
  logic            done_q, done_n;

  logic [W-1:0]    dec_y;
  logic            in_ready;
  logic            accept;
  logic            dwell_end;
  logic            last_code;

  decoder_nto2n #(.N(N)) u_dec (
    .sel (bus.in_sel),
    .y   (dec_y)
  );

  // start has priority over a load in the same cycle, so it blocks ready.
  assign in_ready  = (state_q == IDLE) && bus.en && !bus.start;
  assign accept    = bus.in_valid && in_ready;
  assign dwell_end = (cnt_q == LAST_CNT);
  assign last_code = (cur_q == LAST_SEL);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    if (!bus.en) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_n = SCAN;
        SCAN:    if (dwell_end && last_code) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Output logic: next values of the output registers and dwell counter.
  // The DONE-cycle outputs are produced on the edge that enters DONE.
  always_comb begin
    d_n       = d_q;
    d_valid_n = d_valid_q;
    cur_n     = cur_q;
    cnt_n     = cnt_q;
    done_n    = 1'b0;
    if (!bus.en) begin
      d_n       = '0;
      d_valid_n = 1'b0;
      cur_n     = '0;
      cnt_n     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            d_n       = W'(1);
            d_valid_n = 1'b1;
            cur_n     = '0;
            cnt_n     = '0;
          end else if (accept) begin
            d_n       = dec_y;
            d_valid_n = 1'b1;
            cur_n     = bus.in_sel;
          end
        end
        SCAN: begin
          if (dwell_end) begin
            cnt_n = '0;
            if (last_code) begin
              d_n       = '0;
              d_valid_n = 1'b0;
              cur_n     = '0;
              done_n    = 1'b1;
            end else begin
              d_n   = d_q << 1;
              cur_n = cur_q + N'(1);
            end
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        DONE: begin
          cnt_n = '0;
        end
        default: begin
          d_n       = '0;
          d_valid_n = 1'b0;
          cur_n     = '0;
          cnt_n     = '0;
        end
      endcase
    end
  end

  // Output registers and dwell counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q       <= '0;
      d_valid_q <= 1'b0;
      cur_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      d_q       <= d_n;
      d_valid_q <= d_valid_n;
      cur_q     <= cur_n;
      cnt_q     <= cnt_n;
      done_q    <= done_n;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.d         = d_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.cur_sel   = cur_q;
  assign bus.scan_done = done_q;
  assign state_dbg     = state_q;

endmodule
